rv_decode_stage: RTL

Parametrised RV32/RV64 instruction decode pipeline stage. It accepts a fetched instruction word over a valid/ready handshake and splits out all fields (opcode, rd, funct3, rs1, rs2, funct7). It also classifies the instruction format, generates the sign-extended immediate and flags illegal encodings. It sits between fetch and register-read, uses a 2-entry skid buffer for full-throughput backpressure, and supports a synchronous pipeline flush.

---
 rtl/rv_decode_pkg.sv | 41 ++++
 rtl/rv_imm_gen.sv | 51 +++++
 rtl/rv_decode_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared opcodes, format codes and the decoded-instruction bundle for the RV decode stage.
package rv_decode_pkg;

  localparam int unsigned XLEN_MAX = 64;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // pc/imm sized for the widest XLEN; the stage slices down to its own XLEN
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [6:0]          funct7;
    fmt_e                fmt;
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational format classification, sign-extended immediate and illegal-opcode flag.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  always_comb begin
    fmt     = FMT_ILL;
    imm     = '0;
    illegal = 1'b1;
    case (instr[6:0])
      OP_REG: begin
        fmt     = FMT_R;
        illegal = 1'b0;
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt     = FMT_I;
        imm     = XLEN'($signed(instr[31:20]));
        illegal = 1'b0;
      end
      OP_STORE: begin
        fmt     = FMT_S;
        imm     = XLEN'($signed({instr[31:25], instr[11:7]}));
        illegal = 1'b0;
      end
      OP_BRANCH: begin
        fmt     = FMT_B;
        imm     = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        fmt     = FMT_U;
        imm     = XLEN'($signed({instr[31:12], 12'b0}));
        illegal = 1'b0;
      end
      OP_JAL: begin
        fmt     = FMT_J;
        imm     = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Instruction decode pipeline stage: valid/ready input, registered decoded output,
// optional 2-entry skid for full-throughput backpressure, synchronous flush.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned SKID_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  fmt_e            fmt_c;
  logic [XLEN-1:0] imm_c;
  logic            ill_c;
  decoded_t        dec_c;
  decoded_t        out_q;
  logic            out_valid_q;
  logic            accept;
  logic            load;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (instr_i[31:0]),
    .fmt     (fmt_c),
    .imm     (imm_c),
    .illegal (ill_c)
  );

  always_comb begin
    dec_c         = '0;
    dec_c.pc      = XLEN_MAX'(pc_i);
    dec_c.opcode  = instr_i[6:0];
    dec_c.rd      = instr_i[11:7];
    dec_c.funct3  = instr_i[14:12];
    dec_c.rs1     = instr_i[19:15];
    dec_c.rs2     = instr_i[24:20];
    dec_c.funct7  = instr_i[31:25];
    dec_c.fmt     = fmt_c;
    dec_c.imm     = XLEN_MAX'(imm_c);
    dec_c.illegal = ill_c;
  end

  assign accept = in_valid & in_ready;
  assign load   = ~out_valid_q | out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic     skid_valid;
      decoded_t skid_q;

      // in_ready tracks the next skid occupancy so it leaves a flop directly
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          out_q       <= '0;
          skid_valid  <= 1'b0;
          skid_q      <= '0;
          in_ready    <= 1'b1;
        end else if (flush) begin
          out_valid_q <= 1'b0;
          skid_valid  <= 1'b0;
          in_ready    <= 1'b1;
        end else if (load) begin
          in_ready <= 1'b1;
          if (skid_valid) begin
            out_q       <= skid_q;
            out_valid_q <= 1'b1;
            skid_valid  <= 1'b0;
          end else if (accept) begin
            out_q       <= dec_c;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end else if (accept) begin
          skid_q     <= dec_c;
          skid_valid <= 1'b1;
          in_ready   <= 1'b0;
        end
      end
    end else begin : g_noskid
      assign in_ready = out_ready | ~out_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          out_q       <= '0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (load) begin
          if (accept) begin
            out_q       <= dec_c;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign pc_o      = out_q.pc[XLEN-1:0];
  assign opcode    = out_q.opcode;
  assign rd        = out_q.rd;
  assign funct3    = out_q.funct3;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct7    = out_q.funct7;
  assign fmt       = out_q.fmt;
  assign imm       = out_q.imm[XLEN-1:0];
  assign illegal   = out_q.illegal;

  // upper halves of pc/imm are dead when XLEN < XLEN_MAX
  logic unused_hi;
  assign unused_hi = ^{out_q.pc, out_q.imm};

endmodule
